// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, widths and the ID/EX pipeline record with its bubble value.
package cpu_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SRA = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [2:0]        aluoper;
    logic              alusrcb;
    logic              shiftsrca;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [REG_W-1:0]  wreg;
  } id_ex_t;
  localparam id_ex_t BUBBLE = '{
    valid: 1'b0, rs: '0, rt: '0, rs_data: '0, rt_data: '0, imm: '0, shamt: '0,
    aluoper: ALU_ADD, alusrcb: 1'b0, shiftsrca: 1'b0, regwrite: 1'b0,
    memread: 1'b0, memwrite: 1'b0, wreg: '0
  };
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the newest value of one source register; EX/MEM beats MEM/WB, r0 never forwards.
module fwd_mux import cpu_pkg::*; (
  input  logic [REG_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exm_regwrite_i,
  input  logic [REG_W-1:0]  exm_wreg_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              mwb_regwrite_i,
  input  logic [REG_W-1:0]  mwb_wreg_i,
  input  logic [DATA_W-1:0] mwb_data_i,
  output logic [DATA_W-1:0] data_o
);
  logic nz;
  assign nz = idx_i != '0;
  assign data_o = (nz && exm_regwrite_i && exm_wreg_i == idx_i) ? exm_data_i :
                  (nz && mwb_regwrite_i && mwb_wreg_i == idx_i) ? mwb_data_i : reg_data_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB bypassing and load-use bubble insertion.
module id_ex_stage import cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [2:0]  id_aluoper,
  input  logic        id_alusrcb,
  input  logic        id_shiftsrca,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic [4:0]  id_wreg,
  input  logic        stall,
  input  logic        flush,
  input  logic        exm_regwrite,
  input  logic [4:0]  exm_wreg,
  input  logic [31:0] exm_data,
  input  logic        mwb_regwrite,
  input  logic [4:0]  mwb_wreg,
  input  logic [31:0] mwb_data,
  output logic [31:0] Adat,
  output logic [31:0] Bdat,
  output logic [2:0]  ALUoper,
  output logic [31:0] ex_storedata,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [4:0]  ex_wreg,
  output logic        hazard_stall
);
  id_ex_t pipe_q, pipe_d, id_pkt;
  logic [31:0] fwd_a, fwd_b;
  assign id_pkt = '{
    valid: id_valid, rs: id_rs, rt: id_rt, rs_data: id_rs_data, rt_data: id_rt_data,
    imm: id_imm, shamt: id_shamt, aluoper: id_aluoper, alusrcb: id_alusrcb,
    shiftsrca: id_shiftsrca, regwrite: id_regwrite, memread: id_memread,
    memwrite: id_memwrite, wreg: id_wreg
  };
  assign hazard_stall = id_valid && pipe_q.valid && pipe_q.memread && pipe_q.wreg != '0 &&
                        (id_rs == pipe_q.wreg || id_rt == pipe_q.wreg);
  // a global stall freezes the register even over a pending load-use bubble
  always_comb pipe_d = stall ? pipe_q : (flush || hazard_stall) ? BUBBLE : id_pkt;
  always_ff @(posedge clk) pipe_q <= rst ? BUBBLE : pipe_d;
  fwd_mux u_fwd_a (
    .idx_i(pipe_q.rs), .reg_data_i(pipe_q.rs_data),
    .exm_regwrite_i(exm_regwrite), .exm_wreg_i(exm_wreg), .exm_data_i(exm_data),
    .mwb_regwrite_i(mwb_regwrite), .mwb_wreg_i(mwb_wreg), .mwb_data_i(mwb_data),
    .data_o(fwd_a)
  );
  fwd_mux u_fwd_b (
    .idx_i(pipe_q.rt), .reg_data_i(pipe_q.rt_data),
    .exm_regwrite_i(exm_regwrite), .exm_wreg_i(exm_wreg), .exm_data_i(exm_data),
    .mwb_regwrite_i(mwb_regwrite), .mwb_wreg_i(mwb_wreg), .mwb_data_i(mwb_data),
    .data_o(fwd_b)
  );
  assign Adat = pipe_q.shiftsrca ? {27'b0, pipe_q.shamt} : fwd_a;
  assign Bdat = pipe_q.alusrcb ? pipe_q.imm : fwd_b;
  assign ex_storedata = fwd_b;
  assign ALUoper = pipe_q.aluoper;
  assign ex_valid = pipe_q.valid;
  assign ex_regwrite = pipe_q.regwrite;
  assign ex_memread = pipe_q.memread;
  assign ex_memwrite = pipe_q.memwrite;
  assign ex_wreg = pipe_q.wreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, hand-written hazard/stall/flush sequences and a randomized model comparison.
module tb_id_ex_stage;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_alusrcb = 0, id_shiftsrca = 0, id_regwrite = 0, id_memread = 0, id_memwrite = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_shamt = 0, id_wreg = 0;
  logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [2:0] id_aluoper = 0;
  logic stall = 0, flush = 0;
  logic exm_regwrite = 0, mwb_regwrite = 0;
  logic [4:0] exm_wreg = 0, mwb_wreg = 0;
  logic [31:0] exm_data = 0, mwb_data = 0;
  logic [31:0] Adat, Bdat, ex_storedata;
  logic [2:0] ALUoper;
  logic ex_valid, ex_regwrite, ex_memread, ex_memwrite, hazard_stall;
  logic [4:0] ex_wreg;
  int total = 0, bad = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_aluoper(id_aluoper), .id_alusrcb(id_alusrcb), .id_shiftsrca(id_shiftsrca),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_wreg(id_wreg), .stall(stall), .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_wreg(exm_wreg), .exm_data(exm_data),
    .mwb_regwrite(mwb_regwrite), .mwb_wreg(mwb_wreg), .mwb_data(mwb_data),
    .Adat(Adat), .Bdat(Bdat), .ALUoper(ALUoper), .ex_storedata(ex_storedata),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_wreg(ex_wreg), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byp(input logic erw, input logic [4:0] ew, input logic [31:0] ed,
                         input logic mrw, input logic [4:0] mw, input logic [31:0] md);
    exm_regwrite = erw; exm_wreg = ew; exm_data = ed;
    mwb_regwrite = mrw; mwb_wreg = mw; mwb_data = md;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] sh, input logic [2:0] op, input logic srcb, input logic shfa,
                        input logic rw, input logic mr, input logic mw, input logic [4:0] wr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_shamt = sh; id_aluoper = op; id_alusrcb = srcb; id_shiftsrca = shfa;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_wreg = wr;
  endtask

  typedef struct {
    logic [4:0] rs, rt, sh;
    logic [31:0] rsd, rtd, imm;
    logic [2:0] op;
    logic srcb, shfa;
    logic erw; logic [4:0] ew; logic [31:0] ed;
    logic mrw; logic [4:0] mw; logic [31:0] md;
    logic [31:0] exp_a, exp_b, exp_st;
  } vec_t;
  vec_t vecs[6];

  // behavioural model: the instruction currently held in EX, as a plain record
  typedef struct {
    bit v; int rs, rt, sh, op, wr; bit [31:0] rsd, rtd, imm; bit srcb, shfa, rw, mr, mw;
  } ins_t;
  ins_t m;

  function automatic ins_t nop();
    ins_t n;
    n = '{v:0, rs:0, rt:0, sh:0, op:2, wr:0, rsd:0, rtd:0, imm:0, srcb:0, shfa:0, rw:0, mr:0, mw:0};
    return n;
  endfunction

  function automatic bit [31:0] newest(int r, bit [31:0] d);
    if (r == 0) return d;
    if (exm_regwrite && int'(exm_wreg) == r) return exm_data;
    if (mwb_regwrite && int'(mwb_wreg) == r) return mwb_data;
    return d;
  endfunction

  initial begin
    vecs[0] = '{rs:5, rt:6, sh:0, rsd:32'hAAAA, rtd:32'h66, imm:0, op:3'b010, srcb:0, shfa:0,
                erw:1, ew:5, ed:32'h11, mrw:1, mw:5, md:32'h22, exp_a:32'h11, exp_b:32'h66, exp_st:32'h66};
    vecs[1] = '{rs:5, rt:6, sh:0, rsd:32'hAAAA, rtd:32'h66, imm:0, op:3'b000, srcb:0, shfa:0,
                erw:0, ew:5, ed:32'h11, mrw:1, mw:5, md:32'h22, exp_a:32'h22, exp_b:32'h66, exp_st:32'h66};
    vecs[2] = '{rs:0, rt:0, sh:0, rsd:32'h1234, rtd:32'h55, imm:0, op:3'b001, srcb:0, shfa:0,
                erw:1, ew:0, ed:32'h11, mrw:1, mw:0, md:32'h22, exp_a:32'h1234, exp_b:32'h55, exp_st:32'h55};
    vecs[3] = '{rs:1, rt:2, sh:0, rsd:32'h7, rtd:32'h99, imm:32'hFFFFFFF0, op:3'b010, srcb:1, shfa:0,
                erw:0, ew:0, ed:0, mrw:0, mw:0, md:0, exp_a:32'h7, exp_b:32'hFFFFFFF0, exp_st:32'h99};
    vecs[4] = '{rs:9, rt:7, sh:4, rsd:32'h5, rtd:32'h80, imm:0, op:3'b011, srcb:0, shfa:1,
                erw:1, ew:9, ed:32'hBEEF, mrw:1, mw:7, md:32'h300, exp_a:32'h4, exp_b:32'h300, exp_st:32'h300};
    vecs[5] = '{rs:4, rt:3, sh:0, rsd:32'h40, rtd:32'h1, imm:32'h10, op:3'b010, srcb:1, shfa:0,
                erw:1, ew:3, ed:32'hDEAD, mrw:1, mw:4, md:32'h44, exp_a:32'h44, exp_b:32'h10, exp_st:32'hDEAD};

    // reset
    rst = 1; tick(); tick();
    chk("rst_aluoper", 32'(ALUoper), 32'h2);
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_adat", Adat, 0);
    chk("rst_bdat", Bdat, 0);
    chk("rst_hazard", 32'(hazard_stall), 0);
    chk("rst_ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_wreg}, 0);
    rst = 0;

    // vector table
    for (int i = 0; i < 6; i++) begin
      set_byp(0, 0, 0, 0, 0, 0);
      set_id(1, vecs[i].rs, vecs[i].rt, vecs[i].rsd, vecs[i].rtd, vecs[i].imm, vecs[i].sh,
             vecs[i].op, vecs[i].srcb, vecs[i].shfa, 1, 0, 0, 5'd10);
      tick();
      set_byp(vecs[i].erw, vecs[i].ew, vecs[i].ed, vecs[i].mrw, vecs[i].mw, vecs[i].md);
      #1;
      chk($sformatf("v%0d_adat", i), Adat, vecs[i].exp_a);
      chk($sformatf("v%0d_bdat", i), Bdat, vecs[i].exp_b);
      chk($sformatf("v%0d_store", i), ex_storedata, vecs[i].exp_st);
      chk($sformatf("v%0d_op", i), 32'(ALUoper), 32'(vecs[i].op));
    end

    // load-use: lw r8 in EX, add r9,r8,r1 in ID
    set_byp(0, 0, 0, 0, 0, 0);
    set_id(1, 2, 0, 32'h100, 0, 32'h4, 0, 3'b010, 1, 0, 1, 1, 0, 5'd8);
    tick();
    chk("lw_memread", {ex_valid, ex_memread, ex_wreg}, {1'b1, 1'b1, 5'd8});
    set_id(1, 8, 1, 32'hBAD0, 32'h1, 0, 0, 3'b010, 0, 0, 1, 0, 0, 5'd9);
    #1;
    chk("lu_hazard", 32'(hazard_stall), 1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_op", 32'(ALUoper), 32'h2);
    chk("lu_hazard_clear", 32'(hazard_stall), 0);
    tick();
    set_byp(1, 5'd20, 32'h7777, 1, 5'd8, 32'hCAFE);
    #1;
    chk("lu_add_valid", {ex_valid, ex_wreg}, {1'b1, 5'd9});
    chk("lu_add_adat", Adat, 32'hCAFE);
    chk("lu_add_bdat", Bdat, 32'h1);

    // stall+flush together hold, flush alone bubbles
    set_byp(0, 0, 0, 0, 0, 0);
    set_id(1, 3, 4, 32'h33, 32'h44, 0, 0, 3'b110, 0, 0, 1, 0, 0, 5'd12);
    tick();
    set_id(1, 6, 7, 32'h66, 32'h77, 0, 0, 3'b001, 0, 0, 0, 0, 1, 5'd13);
    stall = 1; flush = 1;
    tick();
    chk("sf_hold_op", 32'(ALUoper), 32'h6);
    chk("sf_hold_a", Adat, 32'h33);
    chk("sf_hold_ctrl", {ex_valid, ex_regwrite, ex_memwrite, ex_wreg}, {1'b1, 1'b1, 1'b0, 5'd12});
    stall = 0;
    tick();
    flush = 0;
    chk("flush_bubble", {ex_valid, ex_regwrite, ex_memwrite, ALUoper}, {1'b0, 1'b0, 1'b0, 3'b010});

    // reset during stall
    tick();
    chk("pre_rst_valid", 32'(ex_valid), 1);
    stall = 1; rst = 1;
    tick();
    chk("rst_in_stall", {ex_valid, ex_memwrite, ex_wreg}, 0);
    stall = 0;
    tick();
    rst = 0;

    // randomized run against the model
    m = nop();
    for (int c = 0; c < 3000; c++) begin
      bit exp_hz;
      rst = ($urandom_range(99) < 2);
      stall = ($urandom_range(99) < 20);
      flush = ($urandom_range(99) < 15);
      set_id($urandom_range(9) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)), $urandom, $urandom,
             $urandom, 5'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(2) == 0, 1'($urandom), 5'($urandom_range(7)));
      #1;
      exp_hz = id_valid && m.v && m.mr && m.wr != 0 && (int'(id_rs) == m.wr || int'(id_rt) == m.wr);
      chk("rnd_hazard", 32'(hazard_stall), 32'(exp_hz));
      if (rst || (!stall && (flush || exp_hz))) m = nop();
      else if (!stall)
        m = '{v:id_valid, rs:id_rs, rt:id_rt, sh:id_shamt, op:id_aluoper, wr:id_wreg, rsd:id_rs_data,
              rtd:id_rt_data, imm:id_imm, srcb:id_alusrcb, shfa:id_shiftsrca, rw:id_regwrite,
              mr:id_memread, mw:id_memwrite};
      tick();
      set_byp(1'($urandom), 5'($urandom_range(7)), $urandom, 1'($urandom), 5'($urandom_range(7)), $urandom);
      #1;
      chk("rnd_adat", Adat, m.shfa ? 32'(m.sh) : newest(m.rs, m.rsd));
      chk("rnd_bdat", Bdat, m.srcb ? m.imm : newest(m.rt, m.rtd));
      chk("rnd_store", ex_storedata, newest(m.rt, m.rtd));
      chk("rnd_ctrl", {ALUoper, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_wreg},
          {3'(m.op), m.v, m.rw, m.mr, m.mw, 5'(m.wr)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
